// File: rtl/atm_tx_arbiter.sv
// atm_tx_arbiter: per-Tx-port round-robin cell arbiter and byte mux for the 4x4 ATM router.
// Optional macro ATM_TX_ARB_STATS_EN adds cell_count / grant_count statistics outputs.
`default_nettype none

module atm_tx_arbiter #(
  parameter int NUM_RX     = 4,
  parameter int CELL_BYTES = 53,
  parameter int DATA_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RX-1:0]        req,
  input  logic [NUM_RX*DATA_W-1:0] rx_data,
  input  logic [NUM_RX-1:0]        rx_valid,
  output logic [NUM_RX-1:0]        rx_ready,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [NUM_RX-1:0]        grant,
  output logic                     busy,
  output logic                     cell_done
`ifdef ATM_TX_ARB_STATS_EN
  ,
  output logic [15:0]              cell_count,
  output logic [NUM_RX*16-1:0]     grant_count
`endif
);

  localparam int IDX_W = (NUM_RX > 1) ? $clog2(NUM_RX) : 1;
  localparam int CNT_W = (CELL_BYTES > 1) ? $clog2(CELL_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(CELL_BYTES - 1);
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(NUM_RX - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_RX-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               beat;
  logic               last_beat;

  // Search starts one past the last owner so every requester is served within NUM_RX cells.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_RX; i++) begin
      cand_idx = IDX_W'((int'(ptr_q) + i) % NUM_RX);
      if (!pick_vld && req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    rx_ready = '0;
    if (state_q == XFER) begin
      tx_data          = rx_data[gidx_q*DATA_W +: DATA_W];
      tx_valid         = rx_valid[gidx_q];
      rx_ready[gidx_q] = tx_ready;
    end
  end

  assign beat      = (state_q == XFER) && tx_valid && tx_ready;
  assign last_beat = beat && (cnt_q == LAST_BYTE);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = XFER;
          gidx_d  = pick_idx;
          for (int i = 0; i < NUM_RX; i++) begin
            grant_d[i] = (pick_idx == IDX_W'(i));
          end
        end
      end
      XFER: begin
        // Grant is held regardless of req until the whole cell has been accepted.
        if (last_beat) begin
          state_d = IDLE;
          cnt_d   = '0;
          grant_d = '0;
          ptr_d   = gidx_q;
          done_d  = 1'b1;
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == XFER);
  assign cell_done = done_q;

`ifdef ATM_TX_ARB_STATS_EN
  logic [15:0]          cell_cnt_q;
  logic [NUM_RX*16-1:0] gcnt_q;

  // Counters step on the same edge that raises cell_done; 16-bit wrap is natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cell_cnt_q <= '0;
      gcnt_q     <= '0;
    end else if (last_beat) begin
      cell_cnt_q                <= cell_cnt_q + 16'd1;
      gcnt_q[gidx_q*16 +: 16]   <= gcnt_q[gidx_q*16 +: 16] + 16'd1;
    end
  end

  assign cell_count  = cell_cnt_q;
  assign grant_count = gcnt_q;
`endif

endmodule

`default_nettype wire
